// File: rtl/ks_add_sched.sv
// rtl/ks_add_sched.sv - round-robin scheduler sharing one pipelined Kogge-Stone adder among NREQ requesters
// Optional signed-overflow response output enabled by macro KS_ADD_SCHED_OVF_EN.
module ks_add_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_sub,
  input  logic [32*NREQ-1:0]   i_a,
  input  logic [32*NREQ-1:0]   i_b,
  input  logic                 i_hold,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_add_vld,
  output logic [31:0]          o_add_a,
  output logic [31:0]          o_add_b,
  output logic                 o_add_c0,
  input  logic [31:0]          i_add_sum,
  input  logic                 i_add_cout,
  output logic [NREQ-1:0]      o_rsp_vld,
  output logic [31:0]          o_rsp_sum,
  output logic                 o_rsp_cout,
`ifdef KS_ADD_SCHED_OVF_EN
  output logic                 o_rsp_ovf,
`endif
  output logic                 o_idle
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;
  state_t state, state_nxt;

  logic [IDW-1:0]    ptr, gnt_id, add_id;
  logic              gnt_any, arb_en, pipe_empty;
  logic [2*NREQ-1:0] req_rot;
  logic [IDW:0]      id_sum;
  logic [31:0]       sel_a, sel_b;
  logic              sel_sub;
  logic [LAT-1:0]    tag_vld;
  logic [IDW-1:0]    tag_id [LAT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Releasing hold while draining returns straight to RUN without waiting for empty.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (i_hold) state_nxt = DRAIN;
      DRAIN:   if (!i_hold) state_nxt = RUN; else if (pipe_empty) state_nxt = HOLD;
      HOLD:    if (!i_hold) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    arb_en = (state == RUN) && !i_hold;
    o_idle = (state == HOLD);
  end

  // Rotate requests so bit j is requester (ptr+j) mod NREQ; lowest set bit wins.
  always_comb begin
    req_rot = {i_req, i_req} >> ptr;
    gnt_any = 1'b0;
    id_sum  = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        gnt_any = arb_en;
        id_sum  = {1'b0, ptr} + (IDW+1)'(j);
      end
    end
    gnt_id = (id_sum >= (IDW+1)'(NREQ)) ? IDW'(id_sum - (IDW+1)'(NREQ)) : id_sum[IDW-1:0];
    o_gnt  = gnt_any ? (ONE << gnt_id) : '0;
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == IDW'(k)) begin
        sel_a   = i_a[32*k +: 32];
        sel_b   = i_b[32*k +: 32];
        sel_sub = i_sub[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_add_vld <= 1'b0;
      o_add_a   <= '0;
      o_add_b   <= '0;
      o_add_c0  <= 1'b0;
      add_id    <= '0;
      ptr       <= '0;
    end else begin
      o_add_vld <= gnt_any;
      if (gnt_any) begin
        o_add_a  <= sel_a;
        o_add_b  <= sel_sub ? ~sel_b : sel_b;
        o_add_c0 <= sel_sub;
        add_id   <= gnt_id;
        ptr      <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end
    end
  end

  // Stage 0 follows o_add_vld by one cycle, so the last stage lines up with i_add_sum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= o_add_vld;
      tag_id[0]  <= add_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign pipe_empty = !o_add_vld && (tag_vld == '0);
  assign o_rsp_vld  = tag_vld[LAT-1] ? (ONE << tag_id[LAT-1]) : '0;
  assign o_rsp_sum  = i_add_sum;
  assign o_rsp_cout = i_add_cout;

`ifdef KS_ADD_SCHED_OVF_EN
  logic [LAT-1:0] tag_sa, tag_sb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_sa <= '0;
      tag_sb <= '0;
    end else begin
      tag_sa[0] <= o_add_a[31];
      tag_sb[0] <= o_add_b[31];
      for (int i = 1; i < LAT; i++) begin
        tag_sa[i] <= tag_sa[i-1];
        tag_sb[i] <= tag_sb[i-1];
      end
    end
  end

  assign o_rsp_ovf = tag_vld[LAT-1] && (tag_sa[LAT-1] == tag_sb[LAT-1]) &&
                     (i_add_sum[31] != tag_sa[LAT-1]);
`endif

endmodule

// File: tb/tb_ks_add_sched.sv
// tb/tb_ks_add_sched.sv - randomized self-checking bench for ks_add_sched against a transaction-level model
module tb_ks_add_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0, sub = '0;
  logic [32*NREQ-1:0] a = '0, b = '0;
  logic hold = 1'b0;
  logic [NREQ-1:0] gnt, rsp_vld;
  logic add_vld, add_c0, add_cout, rsp_cout, idle;
  logic [31:0] add_a, add_b, add_sum, rsp_sum;
`ifdef KS_ADD_SCHED_OVF_EN
  logic rsp_ovf;
`endif

  always #5 clk = ~clk;

  ks_add_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_sub(sub), .i_a(a), .i_b(b),
    .i_hold(hold), .o_gnt(gnt), .o_add_vld(add_vld), .o_add_a(add_a),
    .o_add_b(add_b), .o_add_c0(add_c0), .i_add_sum(add_sum), .i_add_cout(add_cout),
    .o_rsp_vld(rsp_vld), .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout),
`ifdef KS_ADD_SCHED_OVF_EN
    .o_rsp_ovf(rsp_ovf),
`endif
    .o_idle(idle)
  );

  // Fixed-latency adder: sum appears LAT cycles after the operands are presented.
  logic [32:0] adder_pipe [LAT];
  always @(posedge clk) begin
    adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c0};
    for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
  end
  assign add_sum  = adder_pipe[LAT-1][31:0];
  assign add_cout = adder_pipe[LAT-1][32];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } op_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ptr = 0;
  int mst = 0;
  int last_gnt_cyc = -10;
  logic [31:0] e_a = '0, e_b = '0;
  logic e_c0 = 1'b0;
  op_t q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick();
    if (mst != 0 || hold) return -1;
    for (int i = 0; i < NREQ; i++)
      if (req[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    ptr = 0;
    mst = 0;
    last_gnt_cyc = -10;
    e_a = '0;
    e_b = '0;
    e_c0 = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, return at the next falling edge.
  task automatic step();
    int k;
    bit empty;
    op_t o;
    logic [31:0] ak, bk;
    longint sres;
    #1;
    k = pick();
    check("gnt", gnt, (k >= 0) ? (64'd1 << k) : 64'd0);
    check("add_vld", add_vld, last_gnt_cyc == cyc - 1);
    check("add_a", add_a, e_a);
    check("add_b", add_b, e_b);
    check("add_c0", add_c0, e_c0);
    check("idle", idle, mst == 2);
    if (q.size() > 0 && q[0].due == cyc) begin
      check("rsp_vld", rsp_vld, 64'd1 << q[0].id);
      check("rsp_sum", rsp_sum, q[0].sum);
      check("rsp_cout", rsp_cout, q[0].cout);
`ifdef KS_ADD_SCHED_OVF_EN
      check("rsp_ovf", rsp_ovf, q[0].ovf);
`endif
    end else begin
      check("rsp_vld_idle", rsp_vld, 0);
`ifdef KS_ADD_SCHED_OVF_EN
      check("rsp_ovf_idle", rsp_ovf, 0);
`endif
    end
    empty = (q.size() == 0);
    if (!empty && q[0].due == cyc) void'(q.pop_front());
    if (k >= 0) begin
      ak = a[32*k +: 32];
      bk = b[32*k +: 32];
      o.due = cyc + 1 + LAT;
      o.id  = k;
      if (sub[k]) begin
        o.sum  = ak - bk;
        o.cout = (ak >= bk);
        sres   = longint'($signed(ak)) - longint'($signed(bk));
      end else begin
        o.sum  = ak + bk;
        o.cout = ({1'b0, ak} + {1'b0, bk}) > 33'h0_FFFF_FFFF;
        sres   = longint'($signed(ak)) + longint'($signed(bk));
      end
      o.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      q.push_back(o);
      e_a = ak;
      e_b = sub[k] ? ~bk : bk;
      e_c0 = sub[k];
      ptr = (k + 1) % NREQ;
      last_gnt_cyc = cyc;
    end
    case (mst)
      0: if (hold) mst = 1;
      1: if (!hold) mst = 0; else if (empty) mst = 2;
      default: if (!hold) mst = 0;
    endcase
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (k >= 0) req[k] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_op(input int r, input logic [31:0] av, input logic [31:0] bv, input logic s);
    req[r] = 1'b1;
    sub[r] = s;
    a[32*r +: 32] = av;
    b[32*r +: 32] = bv;
  endtask

  initial begin
    int guard;
    @(negedge clk);
    #1;
    check("rst_add_vld", add_vld, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_idle", idle, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    steps(20);

    set_op(0, 32'h5, 32'h3, 1'b0);
    step();
    #1;
    check("single_add_a", add_a, 32'h5);
    check("single_add_b", add_b, 32'h3);
    steps(LAT);
    #1;
    check("single_rsp_vld", rsp_vld, 4'b0001);
    check("single_rsp_sum", rsp_sum, 32'h8);
    steps(2);

    set_op(2, 32'h3, 32'h5, 1'b1);
    step();
    #1;
    check("sub_add_b", add_b, 32'hFFFF_FFFA);
    check("sub_add_c0", add_c0, 1);
    steps(LAT);
    #1;
    check("sub_rsp_vld", rsp_vld, 4'b0100);
    check("sub_rsp_sum", rsp_sum, 32'hFFFF_FFFE);
    check("sub_rsp_cout", rsp_cout, 0);
    steps(2);

    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NREQ; r++) if (!req[r]) set_op(r, $urandom, $urandom, 1'(r & 1));
      step();
    end
    req = '0;
    steps(LAT + 2);

    for (int r = 0; r < 3; r++) begin
      set_op(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
      step();
    end
    set_op(3, 32'h11, 32'h22, 1'b0);
    hold = 1'b1;
    #1;
    check("drain_gnt_forced", gnt, 0);
    guard = 0;
    while (mst != 2 && guard < 30) begin
      step();
      guard++;
    end
    check("drain_reach_hold", guard < 30, 1);
    steps(2);
    check("drain_idle", idle, 1);
    hold = 1'b0;
    steps(LAT + 4);

    req = '1;
    for (int r = 0; r < NREQ; r++) set_op(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
    steps(4);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_add_vld", add_vld, 0);
    check("mid_rst_rsp_vld", rsp_vld, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    steps(LAT + 4);
    req = '1;
    #1;
    check("rst_ptr_gnt", gnt, 4'b0001);
    step();
    req = '0;
    steps(LAT + 2);

    set_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    steps(LAT + 3);

    for (int c = 0; c < 2000; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req[r] && $urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 7))
            0: set_op(r, 32'h7FFF_FFFF, $urandom_range(0, 3), 1'b0);
            1: set_op(r, 32'h8000_0000, $urandom_range(0, 3), 1'b1);
            default: set_op(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
          endcase
        end
      end
      if ($urandom_range(0, 11) == 0) hold = ~hold;
      step();
    end
    req = '0;
    hold = 1'b0;
    steps(LAT + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
